fabric_config_loader: RTL

Sequencer that streams configuration words from a word-wide source and programs a chain of `NUM_BLOCKS` fabric blocks (data connection blocks and similar), each holding a `CONF_WIDTH`-bit configuration register loaded by `cset`/`c`. Frames are assembled one block at a time on a shared `c` bus, and each assembled frame is committed with a one-hot, single-cycle `cset` pulse. The block sits between the off-fabric configuration port and the per-block `cset`/`c` inputs of the tile array.

---
 rtl/fabric_config_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fabric_config_loader.sv
// Streams IN_WIDTH-bit configuration words into a CONF_WIDTH-bit frame and commits
// one frame per fabric block with a one-hot cset strobe, block 0 first.
module fabric_config_loader #(
    parameter int CONF_WIDTH = 288,
    parameter int NUM_BLOCKS = 4,
    parameter int IN_WIDTH   = 32,
    parameter int WPF        = (CONF_WIDTH + IN_WIDTH - 1) / IN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [CONF_WIDTH-1:0] c,
    output logic [NUM_BLOCKS-1:0] cset,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W   = (WPF > 1) ? $clog2(WPF) : 1;
    localparam int BLK_W   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int LAST_LO = (WPF - 1) * IN_WIDTH;
    localparam int LAST_W  = CONF_WIDTH - LAST_LO;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      word_cnt;
    logic [BLK_W-1:0]      blk;
    logic [CONF_WIDTH-1:0] frame;
    logic                  accept;
    logic                  last_word;
    logic                  last_blk;

    // Handshake: a word transfers on a rising edge where in_valid and in_ready are both 1;
    // in_ready is a registered state decode and never looks at in_valid.
    assign accept    = in_valid && in_ready;
    assign last_word = (word_cnt == CNT_W'(WPF - 1));
    assign last_blk  = (blk == BLK_W'(NUM_BLOCKS - 1));
    assign c         = frame;
    assign state_dbg = state;

    // Words land LSB-first; the final word keeps only the bits that fit in the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame <= '0;
        end else if (accept) begin
            for (int w = 0; w < WPF - 1; w++) begin
                if (word_cnt == CNT_W'(w)) begin
                    frame[w*IN_WIDTH +: IN_WIDTH] <= in_data;
                end
            end
            if (last_word) begin
                frame[CONF_WIDTH-1:LAST_LO] <= in_data[LAST_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            blk      <= '0;
            in_ready <= 1'b0;
            cset     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            cset <= '0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        word_cnt <= '0;
                        blk      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (accept) begin
                        word_cnt <= word_cnt + CNT_W'(1);
                        if (last_word) begin
                            state    <= S_COMMIT;
                            in_ready <= 1'b0;
                            cset     <= NUM_BLOCKS'(1) << blk;
                        end
                    end
                end
                S_COMMIT: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (last_blk) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_LOAD;
                        blk      <= blk + BLK_W'(1);
                        word_cnt <= '0;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
